// File: rtl/mole_judge.sv
// Whack-a-mole game core: spawns moles at LFSR-chosen holes, times each one,
// and judges debounced presses into registered one-cycle verdict pulses.
module mole_judge #(
    parameter int          MOLE_TIMEOUT    = 100000000,
    parameter int          COOLDOWN_CYCLES = 50000000,
    parameter logic [7:0]  LFSR_SEED       = 8'hA5
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_btn_valid,
    input  logic [2:0] i_btn_index,
    output logic [2:0] o_mole_position,
    output logic [2:0] o_user_guess,
    output logic       o_user_right,
    output logic       o_user_wrong,
    output logic       o_miss,
    output logic       o_mole_active
);

    localparam int CNT_MAX = (MOLE_TIMEOUT > COOLDOWN_CYCLES) ? MOLE_TIMEOUT : COOLDOWN_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CW-1:0] UP_LAST = CW'(MOLE_TIMEOUT - 1);
    localparam logic [CW-1:0] CD_LAST = CW'(COOLDOWN_CYCLES - 1);
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SPAWN,
        ST_UP,
        ST_COOLDOWN
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    pos_q, pos_d;
    logic [2:0]    guess_q, guess_d;
    logic          right_q, right_d;
    logic          wrong_q, wrong_d;
    logic          miss_q, miss_d;
    logic          active_q, active_d;
    logic [2:0]    cand;

    always_comb begin
        state_d  = state_q;
        lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        cnt_d    = cnt_q;
        pos_d    = pos_q;
        guess_d  = guess_q;
        right_d  = 1'b0;
        wrong_d  = 1'b0;
        miss_d   = 1'b0;
        active_d = 1'b0;
        // Never respawn in the same hole; 3-bit add wraps 7 to 0.
        cand     = lfsr_q[2:0];
        if (cand == pos_q) begin
            cand = cand + 3'd1;
        end

        if (!i_start) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SPAWN;
                end
                ST_SPAWN: begin
                    pos_d    = cand;
                    cnt_d    = '0;
                    active_d = 1'b1;
                    state_d  = ST_UP;
                end
                ST_UP: begin
                    if (i_btn_valid) begin
                        guess_d = i_btn_index;
                        right_d = (i_btn_index == pos_q);
                        wrong_d = (i_btn_index != pos_q);
                        cnt_d   = '0;
                        state_d = ST_COOLDOWN;
                    end else if (cnt_q == UP_LAST) begin
                        wrong_d = 1'b1;
                        miss_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_COOLDOWN;
                    end else begin
                        cnt_d    = cnt_q + CW'(1);
                        active_d = 1'b1;
                    end
                end
                ST_COOLDOWN: begin
                    if (cnt_q == CD_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_SPAWN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            lfsr_q   <= SEED;
            cnt_q    <= '0;
            pos_q    <= 3'd0;
            guess_q  <= 3'd0;
            right_q  <= 1'b0;
            wrong_q  <= 1'b0;
            miss_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            cnt_q    <= cnt_d;
            pos_q    <= pos_d;
            guess_q  <= guess_d;
            right_q  <= right_d;
            wrong_q  <= wrong_d;
            miss_q   <= miss_d;
            active_q <= active_d;
        end
    end

    assign o_mole_position = pos_q;
    assign o_user_guess    = guess_q;
    assign o_user_right    = right_q;
    assign o_user_wrong    = wrong_q;
    assign o_miss          = miss_q;
    assign o_mole_active   = active_q;

endmodule
